// File: rtl/audio_dma_arbiter.sv
// ---------------------------------------------------------------------------
// audio_dma_arbiter
//   Round-robin arbiter that shares one DMA bus master port between CHANNELS
//   audio fetch engines. The arbiter owns both handshakes. Each grant is held
//   until the bus completes and the grantee drops its request. Rotation
//   restarts one position after the last grantee, so no channel is starved.
//
//   Optional feature macro: AUDIO_DMA_ARB_TIMEOUT_EN
//     defined   : a bus wait longer than TIMEOUT cycles ends the transfer with
//                 data 0 and sets the sticky o_timeout flag.
//     undefined : ISSUE waits indefinitely and o_timeout is held at 0.
//
// Ports
//   i_clock         system clock (posedge)
//   i_reset         asynchronous active-high reset
//   i_req           per-channel level request, held until o_ready
//   i_addr          per-channel word address, channel n = [32n+31:32n]
//   o_ready         per-channel completion, grantee only, high in DONE
//   o_rdata         fetched word, valid while o_ready is non-zero
//   o_dma_request   bus request (registered)
//   o_dma_address   bus address (registered, stable while requesting)
//   i_dma_ready     bus completion, may stay high until request drops
//   i_dma_rdata     bus read data, valid with i_dma_ready
//   o_grant         one-hot current grantee, 0 in IDLE
//   o_timeout       sticky bus-timeout flag
//   i_timeout_clear clears o_timeout
// ---------------------------------------------------------------------------
module audio_dma_arbiter #(
  parameter int CHANNELS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [CHANNELS-1:0]   i_req,
  input  logic [CHANNELS*32-1:0] i_addr,
  output logic [CHANNELS-1:0]   o_ready,
  output logic [31:0]           o_rdata,
  output logic                  o_dma_request,
  output logic [31:0]           o_dma_address,
  input  logic                  i_dma_ready,
  input  logic [31:0]           i_dma_rdata,
  output logic [CHANNELS-1:0]   o_grant,
  output logic                  o_timeout,
  input  logic                  i_timeout_clear
);

  localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [IDXW-1:0]     rr_r, rr_s;
  logic [IDXW-1:0]     gidx_r, gidx_s;
  logic [CHANNELS-1:0] ready_s, grant_s;
  logic [31:0]         rdata_s, addr_s;
  logic                req_s, timeout_s;
  logic                hit_s;
  logic [IDXW-1:0]     hit_idx_s;
  logic [IDXW-1:0]     next_rr_s;

`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]       cnt_r, cnt_s;
  logic                to_set_s;
`else
  // TIMEOUT and the clear input only matter when the timeout feature is built.
  logic [32:0]         unused_s;
  assign unused_s = {i_timeout_clear, 32'(TIMEOUT)};
`endif

  // Rotating priority search: walk offsets from the highest down so the
  // lowest offset from the rr pointer is the last (winning) assignment.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {IDXW{1'b0}};
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      logic [IDXW-1:0] idx_v;
      idx_v = IDXW'((int'(rr_r) + i) % CHANNELS);
      if (i_req[idx_v]) begin
        hit_s     = 1'b1;
        hit_idx_s = idx_v;
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Pointer value one past the current grantee, wrapping to channel 0.
  always_comb begin
    if (gidx_r == IDXW'(CHANNELS - 1)) begin
      next_rr_s = {IDXW{1'b0}};
    end else begin
      next_rr_s = gidx_r + IDXW'(1);
    end
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_s = state_r;
    rr_s    = rr_r;
    gidx_s  = gidx_r;
    ready_s = o_ready;
    grant_s = o_grant;
    rdata_s = o_rdata;
    addr_s  = o_dma_address;
    req_s   = o_dma_request;
`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
    cnt_s    = cnt_r;
    to_set_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (hit_s) begin
          gidx_s  = hit_idx_s;
          addr_s  = i_addr[32*hit_idx_s +: 32];
          grant_s = CHANNELS'(1) << hit_idx_s;
          req_s   = 1'b1;
          state_s = ST_ISSUE;
`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
          cnt_s   = {CW{1'b0}};
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i_dma_ready) begin
          rdata_s = i_dma_rdata;
          ready_s = CHANNELS'(1) << gidx_r;
          req_s   = 1'b0;
          rr_s    = next_rr_s;
          state_s = ST_DONE;
`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          // Bus gave up: complete the grant with zero data and flag it.
          rdata_s  = 32'h0000_0000;
          ready_s  = CHANNELS'(1) << gidx_r;
          req_s    = 1'b0;
          rr_s     = next_rr_s;
          to_set_s = 1'b1;
          state_s  = ST_DONE;
        end else begin
          cnt_s    = cnt_r + CW'(1);
`else
        end else begin
          state_s = ST_ISSUE;
`endif
        end
      end
      ST_DONE: begin
        // Leave only once the bus has released ready and the grantee has
        // seen completion, so a lingering i_dma_ready cannot start a new grant.
        if (!i_req[gidx_r] && !i_dma_ready) begin
          ready_s = {CHANNELS{1'b0}};
          grant_s = {CHANNELS{1'b0}};
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        ready_s = {CHANNELS{1'b0}};
        grant_s = {CHANNELS{1'b0}};
        req_s   = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sticky timeout flag; a new timeout wins over a clear in the same cycle.
  always_comb begin
`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
    if (to_set_s) begin
      timeout_s = 1'b1;
    end else if (i_timeout_clear) begin
      timeout_s = 1'b0;
    end else begin
      timeout_s = o_timeout;
    end
`else
    timeout_s = 1'b0;
`endif
  end

  // FSM state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs, round-robin pointer and grantee index.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rr_r          <= {IDXW{1'b0}};
      gidx_r        <= {IDXW{1'b0}};
      o_ready       <= {CHANNELS{1'b0}};
      o_grant       <= {CHANNELS{1'b0}};
      o_rdata       <= 32'h0000_0000;
      o_dma_address <= 32'h0000_0000;
      o_dma_request <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      rr_r          <= rr_s;
      gidx_r        <= gidx_s;
      o_ready       <= ready_s;
      o_grant       <= grant_s;
      o_rdata       <= rdata_s;
      o_dma_address <= addr_s;
      o_dma_request <= req_s;
      o_timeout     <= timeout_s;
    end
  end

`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
  // Bus wait counter, restarted on every grant.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end
`endif

endmodule

// File: tb/tb_audio_dma_arbiter.sv
// ---------------------------------------------------------------------------
// tb_audio_dma_arbiter
//   Directed bench for audio_dma_arbiter (CHANNELS=4, TIMEOUT=8). Each
//   expected transfer (grantee, address, data) is queued when its requests
//   are raised and popped when the DUT raises o_ready.
// ---------------------------------------------------------------------------
module tb_audio_dma_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   i_req = '0;
  logic [N*32-1:0] i_addr = '0;
  logic [N-1:0]   o_ready;
  logic [31:0]    o_rdata;
  logic           o_dma_request;
  logic [31:0]    o_dma_address;
  logic           i_dma_ready = 1'b0;
  logic [31:0]    i_dma_rdata = 32'h0;
  logic [N-1:0]   o_grant;
  logic           o_timeout;
  logic           i_timeout_clear = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t sb[$];

  audio_dma_arbiter #(.CHANNELS(N), .TIMEOUT(8)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_req           (i_req),
    .i_addr          (i_addr),
    .o_ready         (o_ready),
    .o_rdata         (o_rdata),
    .o_dma_request   (o_dma_request),
    .o_dma_address   (o_dma_address),
    .i_dma_ready     (i_dma_ready),
    .i_dma_rdata     (i_dma_rdata),
    .o_grant         (o_grant),
    .o_timeout       (o_timeout),
    .i_timeout_clear (i_timeout_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input int ch);
    logic [31:0] one;
    one = 32'd1;
    return one << ch;
  endfunction

  task automatic push(input int ch, input logic [31:0] data);
    txn_t t;
    t.ch   = ch;
    t.addr = 32'h0000_1000 + 32'(ch) * 32'h100;
    t.data = data;
    sb.push_back(t);
  endtask

  // Serve the transfer at the head of the scoreboard like a bus slave.
  // wait_n: cycles in ISSUE before ready; hold_n: cycles ready stays high
  // after completion; rereq: grantee raises its request again afterwards.
  task automatic serve(input int wait_n, input int hold_n, input bit rereq);
    int          n;
    int          ch;
    logic [31:0] exp_addr;
    txn_t        t;
    n = 0;
    while (!o_dma_request && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(o_dma_request), 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    ch       = sb[0].ch;
    exp_addr = sb[0].addr;
    check("grant", 32'(o_grant), onehot(ch));
    check("addr", o_dma_address, exp_addr);
    // Address must have been captured at grant time.
    i_addr[32*ch +: 32] = ~exp_addr;
    repeat (wait_n) begin
      tick();
      check("req_hold", 32'(o_dma_request), 32'd1);
      check("addr_hold", o_dma_address, exp_addr);
    end
    i_dma_ready = 1'b1;
    i_dma_rdata = sb[0].data;
    tick();
    t = sb.pop_front();
    check("ready", 32'(o_ready), onehot(t.ch));
    check("rdata", o_rdata, t.data);
    check("req_drop", 32'(o_dma_request), 32'd0);
    i_req[ch]   = 1'b0;
    i_dma_rdata = 32'h0BAD_0BAD;
    repeat (hold_n) begin
      tick();
      check("hold_ready", 32'(o_ready), onehot(ch));
      check("hold_noreq", 32'(o_dma_request), 32'd0);
    end
    i_dma_ready = 1'b0;
    i_addr[32*ch +: 32] = exp_addr;
    tick();
    check("release_ready", 32'(o_ready), 32'd0);
    check("release_grant", 32'(o_grant), 32'd0);
    if (rereq) i_req[ch] = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < N; c++) i_addr[32*c +: 32] = 32'h0000_1000 + 32'(c) * 32'h100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(o_dma_request), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_addr", o_dma_address, 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single transfer on ch0, bus ready after 3 cycles.
    push(0, 32'hCAFE_BABE);
    i_req = 4'b0001;
    serve(3, 0, 1'b0);

    // Reset while in ISSUE on ch1: request falls without waiting for a clock.
    i_req = 4'b0010;
    tick();
    check("pre_rst_req", 32'(o_dma_request), 32'd1);
    check("pre_rst_grant", 32'(o_grant), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_req", 32'(o_dma_request), 32'd0);
    check("async_grant", 32'(o_grant), 32'd0);
    i_req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_idle", 32'(o_dma_request), 32'd0);

    // All four held high: fair order 0,1,2,3,0.
    for (int k = 0; k < 5; k++) push(k % N, 32'hD000_0000 + 32'(k));
    i_req = 4'b1111;
    for (int k = 0; k < 5; k++) serve(1, 0, 1'b1);
    i_req = 4'b0000;
    tick();
    check("rr_idle", 32'(o_dma_request), 32'd0);

    // Move pointer to 3 via ch2, then ch1+ch3 together: ch3 first, then wrap to ch1.
    push(2, 32'h2222_0002);
    i_req = 4'b0100;
    serve(0, 0, 1'b0);
    push(3, 32'h3333_0003);
    push(1, 32'h1111_0001);
    i_req = 4'b1010;
    serve(2, 0, 1'b0);
    serve(0, 0, 1'b0);

    // Bus holds ready 5 cycles after completion while ch0 waits (pointer at 2).
    push(2, 32'h4444_0002);
    push(0, 32'h5555_0000);
    i_req = 4'b0101;
    serve(0, 5, 1'b0);
    serve(0, 0, 1'b0);

`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
    // Bus never ready on ch1 (pointer at 1): timeout after 8 ISSUE cycles.
    push(1, 32'h0000_0000);
    i_req = 4'b0010;
    tick();
    check("to_grant", 32'(o_grant), 32'd2);
    repeat (7) begin
      tick();
      check("to_wait", 32'(o_ready), 32'd0);
    end
    tick();
    begin
      txn_t t;
      t = sb.pop_front();
      check("to_ready", 32'(o_ready), onehot(t.ch));
      check("to_rdata", o_rdata, t.data);
    end
    check("to_flag", 32'(o_timeout), 32'd1);
    check("to_reqdrop", 32'(o_dma_request), 32'd0);
    i_req = 4'b0000;
    tick();
    check("to_sticky", 32'(o_timeout), 32'd1);
    i_timeout_clear = 1'b1;
    tick();
    i_timeout_clear = 1'b0;
    check("to_clear", 32'(o_timeout), 32'd0);
`else
    check("no_timeout", 32'(o_timeout), 32'd0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
